// File: rtl/apb_master_bridge.sv
// Single-outstanding valid/ready to APB master bridge. Legal-address filter,
// SETUP/ACCESS sequencing, bounded PREADY wait, registered response.
module apb_master_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_strb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                PSELx,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic                PREADY,
    input  logic [DATA_W-1:0]   PRDATA
);

    localparam int                STRB_W    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(16'h0400);
    localparam logic [7:0]        LAST_WAIT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t              state, state_d;
    logic [7:0]          wait_cnt, wait_cnt_d;
    logic                req_ready_d, rsp_valid_d, rsp_err_d;
    logic                psel_d, penable_d, pwrite_d;
    logic [DATA_W-1:0]   rsp_rdata_d, pwdata_d;
    logic [ADDR_W-1:0]   paddr_d;
    logic [STRB_W-1:0]   pstrb_d;
    logic                addr_legal;

    // 16 registers, 64-byte aligned, below 0x400
    assign addr_legal = (req_addr[5:0] == 6'd0) && (req_addr < REG_LIMIT);

    always_comb begin
        state_d     = state;
        wait_cnt_d  = wait_cnt;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_err_d   = rsp_err;
        rsp_rdata_d = rsp_rdata;
        psel_d      = PSELx;
        penable_d   = PENABLE;
        pwrite_d    = PWRITE;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        pstrb_d     = PSTRB;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (addr_legal) begin
                        state_d   = SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        pwrite_d  = req_write;
                        paddr_d   = req_addr;
                        pwdata_d  = req_wdata;
                        pstrb_d   = req_write ? req_strb : '0;
                    end else begin
                        // rejected without touching the bus
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = 8'd0;
            end
            ACCESS: begin
                if (PREADY || wait_cnt == LAST_WAIT) begin
                    // completion wins over timeout on the final cycle
                    state_d     = RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    wait_cnt_d  = 8'd0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = !PREADY;
                    rsp_rdata_d = (PREADY && !PWRITE) ? PRDATA : '0;
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            PSELx     <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
        end else begin
            state     <= state_d;
            wait_cnt  <= wait_cnt_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            PSELx     <= psel_d;
            PENABLE   <= penable_d;
            PWRITE    <= pwrite_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            PSTRB     <= pstrb_d;
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed plan items plus random transactions
// scored against a transaction-level model of latency, error and read data.
module tb_apb_master_bridge;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 15;

    logic          PCLK = 1'b0;
    logic          PRESETn;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_strb;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          PSELx, PENABLE, PWRITE, PREADY;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA, PRDATA;
    logic [SW-1:0] PSTRB;

    int total = 0;
    int bad   = 0;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY),
        .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [AW-1:0] a);
        return (a % 64 == 0) && (a < 16'h0400);
    endfunction

    // Entered and left at a negedge with the bridge idle. The bench plays the
    // slave: PREADY rises after 'waits' low ACCESS cycles; noise elsewhere.
    task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] st, input int waits, input logic [DW-1:0] prd,
                           input int bp);
        bit            lg, exp_err, got;
        int            acc_len, exp_cyc, setup_n, access_n, k;
        logic [DW-1:0] exp_rd, held;
        lg       = legal(addr);
        acc_len  = !lg ? 0 : (waits < TO ? waits + 1 : TO);
        exp_err  = !lg || waits >= TO;
        exp_rd   = (!exp_err && !wr) ? prd : '0;
        exp_cyc  = lg ? 2 + acc_len : 1;
        setup_n  = 0;
        access_n = 0;
        got      = 0;
        k        = 0;
        chk("idle_req_ready", req_ready, 1'b1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_strb = st;
        @(posedge PCLK);
        #1 req_valid = 1'b0; req_write = 1'($urandom); req_addr = AW'($urandom);
        req_wdata = $urandom;
        for (k = 1; k <= 60; k++) begin
            @(negedge PCLK);
            chk("penable_without_psel", PENABLE & ~PSELx, 1'b0);
            if (rsp_valid) begin
                got = 1;
                break;
            end
            chk("req_ready_busy", req_ready, 1'b0);
            if (PSELx) begin
                chk("paddr", PADDR, addr);
                chk("pwrite", PWRITE, wr);
                chk("pwdata", PWDATA, wd);
                chk("pstrb", PSTRB, wr ? st : '0);
                if (!PENABLE) begin
                    setup_n++;
                    chk("setup_cycle", k, 1);
                end else begin
                    access_n++;
                end
            end
            if (PSELx && PENABLE) begin
                PREADY = (access_n > waits);
                PRDATA = prd;
            end else begin
                PREADY = 1'($urandom);
                PRDATA = $urandom;
            end
            @(posedge PCLK);
        end
        if (!got) begin
            chk("rsp_never_arrived", 1'b0, 1'b1);
            return;
        end
        chk("rsp_cycle", k, exp_cyc);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("setup_count", setup_n, lg ? 1 : 0);
        chk("access_count", access_n, acc_len);
        chk("psel_in_resp", PSELx, 1'b0);
        chk("req_ready_resp", req_ready, 1'b0);
        held = rsp_rdata;
        if (bp > 0) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0080;
        end
        repeat (bp) begin
            @(posedge PCLK);
            @(negedge PCLK);
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rdata_stable", rsp_rdata, held);
            chk("bp_err_stable", rsp_err, exp_err);
            chk("bp_req_ready", req_ready, 1'b0);
            chk("bp_no_psel", PSELx, 1'b0);
            PREADY = 1'($urandom);
        end
        rsp_ready = 1'b1;
        @(posedge PCLK);
        #1 rsp_ready = 1'b0; req_valid = 1'b0;
        @(negedge PCLK);
        chk("rsp_consumed", rsp_valid, 1'b0);
        chk("ready_after_rsp", req_ready, 1'b1);
        chk("no_psel_after_rsp", PSELx, 1'b0);
    endtask

    initial begin
        PRESETn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_strb = '0; rsp_ready = 1'b0; PREADY = 1'b0; PRDATA = '0;
        #12;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, '0);
        chk("rst_psel_pen", {PSELx, PENABLE, PWRITE}, 3'b000);
        chk("rst_apb_bus", {PADDR, PWDATA, PSTRB}, '0);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);

        // plan: zero-wait write, waited read, illegal addresses
        run_txn(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 0, 32'h0, 0);
        run_txn(1'b0, 16'h03C0, 32'h0, 4'hA, 3, 32'h12345678, 0);
        run_txn(1'b0, 16'h0044, 32'h0, 4'h0, 0, 32'hFFFF0000, 0);
        run_txn(1'b1, 16'h0400, 32'hCAFEF00D, 4'h3, 0, 32'h0, 0);

        // timeout boundary: hung slave, ready on final cycle, long hang
        run_txn(1'b0, 16'h0100, 32'h0, 4'h0, 15, 32'hA5A5A5A5, 0);
        run_txn(1'b0, 16'h0100, 32'h0, 4'h0, 14, 32'h5A5A5A5A, 0);
        run_txn(1'b1, 16'h0200, 32'h11112222, 4'h6, 40, 32'h0, 1);

        // response backpressure then back-to-back zero-wait traffic
        run_txn(1'b0, 16'h0280, 32'h0, 4'hF, 1, 32'h87654321, 5);
        run_txn(1'b1, 16'h0000, 32'h01020304, 4'h1, 0, 32'h0, 0);
        run_txn(1'b0, 16'h0340, 32'h0, 4'h0, 0, 32'h0BADBEEF, 0);

        // asynchronous reset while in ACCESS
        req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0080;
        req_wdata = 32'h77777777; req_strb = 4'hF;
        @(posedge PCLK);
        #1 req_valid = 1'b0; PREADY = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("pre_rst_access", {PSELx, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        chk("midrst_psel_pen", {PSELx, PENABLE}, 2'b00);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_req_ready", req_ready, 1'b1);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_idle", {req_ready, rsp_valid, PSELx}, 3'b100);

        // random traffic
        for (int i = 0; i < 40; i++) begin
            logic [AW-1:0] a;
            int            w;
            if ($urandom_range(0, 9) < 7) a = AW'($urandom_range(0, 15)) << 6;
            else                          a = AW'($urandom);
            w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(13, 20)) : int'($urandom_range(0, 4));
            run_txn(1'($urandom), a, $urandom, SW'($urandom), w, $urandom, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
